// File: rtl/coin_pulse_emitter.sv
// Serial coin pay-out: greedily splits a cent amount into quarters, dimes and
// nickels and emits each coin as one high pulse whose width identifies it.
module coin_pulse_emitter #(
  parameter int AMOUNT_W       = 7,
  parameter int DIME_CYCLES    = 3,
  parameter int NICKEL_CYCLES  = 7,
  parameter int QUARTER_CYCLES = 11,
  parameter int GAP_CYCLES     = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AMOUNT_W-1:0] amount,
  output logic                ready,
  output logic                coinPulse,
  output logic [1:0]          coinType,
  output logic [3:0]          coinCount,
  output logic                done,
  output logic [2:0]          residue,
  output logic [2:0]          state_dbg
);

  localparam int MAX_DN  = (DIME_CYCLES > NICKEL_CYCLES) ? DIME_CYCLES : NICKEL_CYCLES;
  localparam int MAX_DNQ = (MAX_DN > QUARTER_CYCLES) ? MAX_DN : QUARTER_CYCLES;
  localparam int MAX_ALL = (MAX_DNQ > GAP_CYCLES) ? MAX_DNQ : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [1:0] COIN_NONE    = 2'd0;
  localparam logic [1:0] COIN_NICKEL  = 2'd1;
  localparam logic [1:0] COIN_DIME    = 2'd2;
  localparam logic [1:0] COIN_QUARTER = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [AMOUNT_W-1:0] rem, rem_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                pulse_n;
  logic [1:0]          type_n;
  logic [3:0]          count_n;
  logic                done_n;
  logic [2:0]          residue_n;

  logic [1:0]          sel_type;
  logic [AMOUNT_W-1:0] sel_rem;
  logic [CNT_W-1:0]    sel_len;
  logic                do_select;

  // Handshake: start is taken only on an edge where ready=1 (IDLE); at any
  // other time start and amount are ignored and nothing is queued.
  assign ready     = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= '0;
      cnt       <= '0;
      coinPulse <= 1'b0;
      coinType  <= COIN_NONE;
      coinCount <= 4'd0;
      done      <= 1'b0;
      residue   <= 3'd0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      cnt       <= cnt_n;
      coinPulse <= pulse_n;
      coinType  <= type_n;
      coinCount <= count_n;
      done      <= done_n;
      residue   <= residue_n;
    end
  end

  // Greedy coin choice; each subtraction is guarded by its compare.
  always_comb begin
    sel_type = COIN_NONE;
    sel_rem  = rem;
    sel_len  = '0;
    if (rem >= AMOUNT_W'(25)) begin
      sel_type = COIN_QUARTER;
      sel_rem  = rem - AMOUNT_W'(25);
      sel_len  = CNT_W'(QUARTER_CYCLES - 1);
    end else if (rem >= AMOUNT_W'(10)) begin
      sel_type = COIN_DIME;
      sel_rem  = rem - AMOUNT_W'(10);
      sel_len  = CNT_W'(DIME_CYCLES - 1);
    end else if (rem >= AMOUNT_W'(5)) begin
      sel_type = COIN_NICKEL;
      sel_rem  = rem - AMOUNT_W'(5);
      sel_len  = CNT_W'(NICKEL_CYCLES - 1);
    end
  end

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    cnt_n     = cnt;
    pulse_n   = coinPulse;
    type_n    = coinType;
    count_n   = coinCount;
    done_n    = 1'b0;
    residue_n = residue;
    do_select = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          rem_n   = amount;
          count_n = 4'd0;
          state_n = SELECT;
        end
      end
      SELECT: do_select = 1'b1;
      PULSE: begin
        if (cnt == '0) begin
          pulse_n = 1'b0;
          type_n  = COIN_NONE;
          cnt_n   = CNT_W'(GAP_CYCLES - 1);
          state_n = GAP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        // The last gap cycle doubles as the next coin decision.
        if (cnt == '0) begin
          do_select = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        residue_n = 3'd0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (do_select) begin
      if (sel_type != COIN_NONE) begin
        pulse_n = 1'b1;
        type_n  = sel_type;
        count_n = coinCount + 4'd1;
        rem_n   = sel_rem;
        cnt_n   = sel_len;
        state_n = PULSE;
      end else begin
        residue_n = rem[2:0];
        done_n    = 1'b1;
        state_n   = DONE;
      end
    end
  end

endmodule

// File: doc/coin_pulse_emitter.md
Name: coin_pulse_emitter

Overview:
- Transmit-side counterpart to the vending machine coin-sensor receiver. It pays out change as serial coin pulses on a single line.
- Given a cent amount, it greedily decomposes the amount into quarters, dimes and nickels.
- Each coin is emitted as one high pulse whose length in clock cycles identifies the coin, with fixed low gaps between pulses.
- It drives the change-return chute model, and its output is directly consumable by the vending machine coin-sensor input in loopback benches.

Parameters:
- AMOUNT_W, 7, width of requested amount in cents (max 127).
- DIME_CYCLES, 3, coinPulse high cycles for a dime (10c).
- NICKEL_CYCLES, 7, coinPulse high cycles for a nickel (5c).
- QUARTER_CYCLES, 11, coinPulse high cycles for a quarter (25c).
- GAP_CYCLES, 3, minimum low cycles between consecutive pulses and after the last pulse (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge; 0 = reset.
- start  in  1  request strobe; accepted only when ready=1.
- amount  in  AMOUNT_W  cents to pay out; sampled with accepted start.
- ready  out  1  high when idle and able to accept start.
- coinPulse  out  1  serial coin line; registered output.
- coinType  out  2  coin currently being emitted: 0 none, 1 nickel, 2 dime, 3 quarter.
- coinCount  out  4  coins emitted in current/last transaction.
- done  out  1  one-cycle strobe at end of transaction.
- residue  out  3  cents not payable (amount mod 5); valid while done=1, else 0.

Behaviour:
- Reset (reset=0 at an edge): state IDLE, ready=1, coinPulse=0, coinType=0, coinCount=0, done=0, residue=0, remainder cleared. Reset mid-pulse forces coinPulse low at that same edge; no partial coin is completed.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: ready=1.
  - At edge E0 with start=1: remainder<=amount, coinCount<=0, ready<=0, go SELECT.
  - start=0: stay IDLE.
- SELECT (one cycle; the coin is chosen at edge E0+1):
  - remainder>=25: quarter, remainder-=25.
  - else remainder>=10: dime, remainder-=10.
  - else remainder>=5: nickel, remainder-=5.
  - On a coin choice: coinPulse<=1, coinType<=coin, coinCount+=1, load width counter, go PULSE.
  - Else: residue<=remainder[2:0], done<=1, go DONE.
- PULSE: coinPulse stays high exactly the coin's *_CYCLES clock cycles. Then coinPulse<=0, coinType<=0, go GAP.
- GAP: coinPulse low. The next pulse rises exactly GAP_CYCLES cycles after the falling edge. The final SELECT decision is folded into the last GAP cycle, so the inter-pulse low time is exactly GAP_CYCLES.
- After the last coin, done rises exactly GAP_CYCLES cycles after the last falling edge of coinPulse.
- DONE: done=1 for exactly one cycle, ready=0; next edge: done<=0, residue<=0, ready<=1, go IDLE. coinCount holds until the next accepted start.
- Zero/sub-nickel amount: no pulse; done=1 in the cycle after E0+1 (two edges after start accepted).
- start while ready=0 (including the DONE cycle) is ignored, with no queuing; amount is not re-sampled.
- Greedy is exact for multiples of 5; residue is always 0..4.
- Arithmetic: remainder is AMOUNT_W bits and never underflows, because each subtraction is guarded by its compare.
- Max coins for 127 = 5Q + 0 = 5, plus residue 2. Max coinCount = 6 (e.g. 120 = 4Q+2D). 4 bits suffice; no wrap.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1, amount=25 -> coinPulse=0, ready=1, done=0, coinCount=0 throughout; release -> still idle until a fresh start.
- amount=40 -> pulses high 11, 3, 7 cycles (Q, D, N), each separated by exactly 3 low cycles; done strobe 3 cycles after last fall; coinCount=3, residue=0.
- amount=95 -> Q,Q,Q,D,D (11,11,11,3,3); coinCount=5. Loopback into VendingMachine (dimeMin 2..quarterMax 12) yields the dispense count matching the fed credit.
- amount=0 and amount=4 -> no coinPulse activity; done one cycle, two edges after start; residue=0 and 4 respectively; coinCount=0.
- amount=17 -> D then N (3, 7 cycles); residue=2. Assert start with amount=50 mid-transaction -> ignored, total pulses still 2.
- Reset asserted on the 5th cycle of a quarter pulse (amount=30) -> coinPulse low at that edge, ready=1 next cycle, no done strobe. A new start with amount=10 then emits a single 3-cycle pulse.
